// File: rtl/cnt_arbiter_pkg.sv
// Shared definitions for the counting arbiter: default sizes, index width helper, one-hot encoder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cnt_arbiter_pkg;

    // Default geometry of the arbiter.
    localparam int NREQ_DEF = 4;
    localparam int WIDTH_DEF = 32;

    // Upper bound on requesters; sizes the one-hot helper below.
    localparam int MAX_NREQ = 32;
    localparam int IDX_MAX_W = 5;

    // Width of a client index (round-robin pointer, cfg_sel) for n clients.
    // A single client still gets a 1-bit index so no port collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W_DEF = idx_width(NREQ_DEF);

    // One-hot encode a client index. Callers cast the result down to NREQ bits.
    function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        logic [MAX_NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cnt_arbiter_if.sv
// Bundles the arbiter's control, config, grant and readback signals.
// Latency: n/a (wires only).
// Backpressure: none; request lines are level-sensitive and simply held until granted.
//
// master: drives en/req/clr/cfg_*, observes gnt/rd_value/done/busy.
// slave : the arbiter itself.
interface cnt_arbiter_if
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int SEL_W = idx_width(NREQ);

    logic             en;         // 1 = arbitrate, 0 = halt (counts and pointer hold)
    logic [NREQ-1:0]  req;        // per-client increment request, level-sensitive
    logic [NREQ-1:0]  clr;        // per-client synchronous clear of count and done
    logic             cfg_we;     // limit write strobe
    logic [SEL_W-1:0] cfg_sel;    // client for limit write and count readback
    logic [WIDTH-1:0] cfg_limit;  // limit value written on cfg_we
    logic [NREQ-1:0]  gnt;        // registered one-hot grant, cycle after the increment edge
    logic [WIDTH-1:0] rd_value;   // combinational count[cfg_sel]
    logic [NREQ-1:0]  done;       // registered, client reached its limit
    logic             busy;       // combinational, some client is eligible right now

    modport master (
        output en, req, clr, cfg_we, cfg_sel, cfg_limit,
        input  gnt, rd_value, done, busy
    );

    modport slave (
        input  en, req, clr, cfg_we, cfg_sel, cfg_limit,
        output gnt, rd_value, done, busy
    );

endinterface

// File: rtl/cnt_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible client strictly after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; win_vld is low when nothing is eligible.
//
// Ports: eligible[NREQ] in, ptr (last winner) in, win_idx / win_vld out.
module cnt_rr_pick
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int SEL_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win_idx,
    output logic             win_vld
);

    // Walk the offsets from farthest to nearest so the nearest eligible client
    // (ptr+1 first) is the last one to overwrite the result.
    always_comb begin
        int idx;
        win_idx = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (eligible[SEL_W'(idx)]) begin
                win_idx = SEL_W'(idx);
                win_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit incrementer among NREQ counting clients.
// Latency: count updates at the grant edge; gnt/done are registered and appear the cycle after.
// Backpressure: req is held by the client; done clients are masked until cleared, en=0 freezes all.
//
// Ports: m_clock, p_reset (async, active-low), bus (cnt_arbiter_if.slave).
module cnt_arbiter
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic          m_clock,
    input  logic          p_reset,
    cnt_arbiter_if.slave  bus
);

    localparam int SEL_W = idx_width(NREQ);

    // State
    logic [WIDTH-1:0] count_q [NREQ];
    logic [WIDTH-1:0] count_d [NREQ];
    logic [WIDTH-1:0] limit_q [NREQ];
    logic [WIDTH-1:0] limit_d [NREQ];
    logic [NREQ-1:0]  done_q, done_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Arbitration
    logic [NREQ-1:0]  eligible;
    logic [SEL_W-1:0] win_idx;
    logic             win_vld;
    logic [WIDTH-1:0] inc_sum;
    logic             sel_ok;

    // A clear in the same cycle removes the client from contention so the
    // grant goes to someone else instead of being wasted on a reset count.
    assign eligible = {NREQ{bus.en}} & bus.req & ~done_q & ~bus.clr;

    cnt_rr_pick #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    // The one shared incrementer: its operand is muxed by the winner index.
    assign inc_sum = count_q[win_idx] + WIDTH'(1);

    // cfg_sel can exceed NREQ-1 when NREQ is not a power of two.
    assign sel_ok = (int'(bus.cfg_sel) < NREQ);

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        done_d  = done_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;

        if (win_vld) begin
            count_d[win_idx] = inc_sum;
            ptr_d            = win_idx;
            gnt_d            = NREQ'(onehot(IDX_MAX_W'(win_idx)));
            // Exact-equality compare: a limit written below the current count
            // is only hit after the counter wraps. Zero means free-running.
            if ((limit_q[win_idx] != '0) && (inc_sum == limit_q[win_idx])) begin
                done_d[win_idx] = 1'b1;
            end
        end

        // Clear overrides any update above. A cleared client is never the winner,
        // so this only ever discards its own state.
        for (int i = 0; i < NREQ; i++) begin
            if (bus.clr[i]) begin
                count_d[i] = '0;
                done_d[i]  = 1'b0;
            end
        end

        // Limit writes land at the edge; the done compare above used limit_q,
        // so a same-edge increment sees the old limit.
        if (bus.cfg_we && sel_ok) begin
            limit_d[bus.cfg_sel] = bus.cfg_limit;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            count_q <= '{default: '0};
            limit_q <= '{default: '0};
            done_q  <= '0;
            gnt_q   <= '0;
            // Pointer parked on the last client so client 0 wins first.
            ptr_q   <= SEL_W'(NREQ - 1);
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            done_q  <= done_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = win_vld;
    assign bus.rd_value = sel_ok ? count_q[bus.cfg_sel] : '0;

endmodule

// File: doc/cnt_arbiter.md
CNT_ARBITER -- requirements
Module: cnt_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the incrementer.
REQ-002 Parameter WIDTH, default 32, counter width in bits.
REQ-003 m_clock  input  1  single clock, all state updates on its rising edge.
REQ-004 p_reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 en  input  1  1 = arbitration runs; 0 = halt, no grants issued, counts hold.
REQ-006 req  input  NREQ  per-client increment request, level-sensitive.
REQ-007 clr  input  NREQ  per-client synchronous clear of count and done.
REQ-008 cfg_we  input  1  write strobe for per-client limit.
REQ-009 cfg_sel  input  log2(NREQ)  client index for cfg write and rd_value readback.
REQ-010 cfg_limit  input  WIDTH  limit value written on cfg_we.
REQ-011 gnt  output  NREQ  registered one-hot, pulses one cycle after the increment edge.
REQ-012 rd_value  output  WIDTH  combinational readback of count[cfg_sel].
REQ-013 done  output  NREQ  registered, set when client count reaches its limit.
REQ-014 busy  output  1  combinational, 1 when en=1 and at least one eligible request exists.

Function
REQ-015 Client i is eligible when en=1, req[i]=1, done[i]=0, clr[i]=0.
REQ-016 At each edge with eligible clients, exactly one winner is chosen round-robin, searching from ptr+1 upward with wrap; ptr <= winner.
REQ-017 Winner count is incremented by 1 modulo 2^WIDTH at that edge; no other count changes.
REQ-018 gnt is one-hot of the winner in the cycle after the edge, else all zeros; a client asserting req continuously receives at most one grant per NREQ cycles while the other NREQ-1 clients are also requesting.
REQ-019 After an increment, done[w] is set when the new count equals limit[w] and limit[w] != 0.
REQ-020 limit=0 means free-running: all-ones wraps to 0, done never set.
REQ-021 A done client receives no grants until cleared; its count holds.
REQ-022 clr[i] has priority over increment: count[i] <= 0, done[i] <= 0, no grant to i that cycle; round-robin proceeds among the rest.
REQ-023 cfg_we writes limit[cfg_sel] at the edge; a same-edge increment compares against the old limit.
REQ-024 Writing a limit below the current count does not set done; the count then runs to the limit only after wrap.
REQ-025 en=0 mid-operation: no increments, gnt zero next cycle, ptr and counts hold; clr and cfg writes still act.
REQ-026 Single requester with all others idle is granted every cycle.

Reset
REQ-027 On p_reset=0: all counts 0, all limits 0, done 0, gnt 0, ptr = NREQ-1 (so client 0 wins first).
REQ-028 Reset mid-operation discards any pending grant; first grant after release is 2 edges after first eligible edge, i.e. increment edge then gnt cycle.

Structure
REQ-029 Shared package holds NREQ/WIDTH defaults, ptr index width, and the one-hot encode function.
REQ-030 One sub-module cnt_rr_pick: combinational round-robin picker (eligible vector, ptr -> winner index, valid).
REQ-031 A single WIDTH-bit incrementer is instantiated once and multiplexed by winner index.

Verification
REQ-032 Reset release, req=4'b1111, limits 0 -> gnt sequence 0001,0010,0100,1000,0001; each count 1 after 4 grants.
REQ-033 limit[2]=3, req[2] only -> 3 consecutive grants, done[2]=1 after third, no further gnt[2], count[2]=3.
REQ-034 count[1]=32'hFFFFFFFF, limit 0, one grant -> count[1]=0, done[1]=0.
REQ-035 clr[0] and eligible req[0],req[1] same edge -> count[0]=0, winner client 1, done[0]=0.
REQ-036 en dropped after two grants with req=4'b1111 -> gnt 0 next cycle, counts hold; en restored -> grant resumes at next client in rotation.
REQ-037 p_reset asserted between increment edge and gnt cycle -> gnt stays 0, all counts 0, next first grant to client 0.
